// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: hazard-unit controls, branch redirect, instruction-memory
// read port and the IF/ID register outputs. master = surrounding pipeline, slave = fetch stage.
interface pc_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            NeedBranchE;
    logic [XLEN-1:0] PCTargetE;
    logic [31:0]     InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            FlushE;
    logic            MisalignFault;

    modport master (
        output StallF, StallD, FlushD, NeedBranchE, PCTargetE, InstrF,
        input  PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, FlushE, MisalignFault
    );

    modport slave (
        input  StallF, StallD, FlushD, NeedBranchE, PCTargetE, InstrF,
        output PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, FlushE, MisalignFault
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// RISC-V fetch stage: PC register, IF/ID register and branch redirect/squash.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC.
module pc_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input logic             clk,
    input logic             reset,
    pc_fetch_stage_if.slave fetchBus
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic [XLEN-1:0] pcF_r;
    logic [XLEN-1:0] pcPlus4F_s;
    logic [XLEN-1:0] redirectPc_s;
    logic [XLEN-1:0] pcNext_s;
    logic            misalign_s;
    logic            fault_r;

    logic [31:0]     instrD_r;
    logic [XLEN-1:0] pcD_r;
    logic [XLEN-1:0] pcPlus4D_r;
    logic            validD_r;
    logic [31:0]     instrDNext_s;
    logic [XLEN-1:0] pcDNext_s;
    logic [XLEN-1:0] pcPlus4DNext_s;
    logic            validDNext_s;

    assign pcPlus4F_s = pcF_r + PC_STEP;

`ifdef PC_MISALIGN_TRAP_EN
    // Redirect target selection: misaligned targets are sent to the trap vector.
    always_comb begin
        misalign_s   = |fetchBus.PCTargetE[1:0];
        redirectPc_s = fetchBus.PCTargetE;
        if (misalign_s) begin
            redirectPc_s = TRAP_VEC;
        end else begin
            redirectPc_s = fetchBus.PCTargetE;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_r <= 1'b0;
        end else if (fetchBus.NeedBranchE && misalign_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end
`else
    logic unusedTrap_s;

    // Redirect target selection: low two target bits are dropped.
    always_comb begin
        misalign_s   = 1'b0;
        redirectPc_s = {fetchBus.PCTargetE[XLEN-1:2], 2'b00};
    end

    assign fault_r      = 1'b0;
    assign unusedTrap_s = ^{TRAP_VEC, fetchBus.PCTargetE[1:0], misalign_s};
`endif

    // PC next-state: a redirect overrides a fetch stall.
    always_comb begin
        pcNext_s = pcF_r;
        if (fetchBus.NeedBranchE) begin
            pcNext_s = redirectPc_s;
        end else if (fetchBus.StallF) begin
            pcNext_s = pcF_r;
        end else begin
            pcNext_s = pcPlus4F_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcF_r <= RESET_PC;
        end else begin
            pcF_r <= pcNext_s;
        end
    end

    // IF/ID next-state: a squash keeps PCD/PCPlus4D so only the bubble marker changes.
    always_comb begin
        instrDNext_s   = instrD_r;
        pcDNext_s      = pcD_r;
        pcPlus4DNext_s = pcPlus4D_r;
        validDNext_s   = validD_r;
        if (fetchBus.FlushD || fetchBus.NeedBranchE) begin
            instrDNext_s = NOP_INSTR;
            validDNext_s = 1'b0;
        end else if (fetchBus.StallD) begin
            instrDNext_s   = instrD_r;
            pcDNext_s      = pcD_r;
            pcPlus4DNext_s = pcPlus4D_r;
            validDNext_s   = validD_r;
        end else begin
            instrDNext_s   = fetchBus.InstrF;
            pcDNext_s      = pcF_r;
            pcPlus4DNext_s = pcPlus4F_s;
            validDNext_s   = 1'b1;
        end
    end

    // IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrD_r   <= NOP_INSTR;
            pcD_r      <= '0;
            pcPlus4D_r <= '0;
            validD_r   <= 1'b0;
        end else begin
            instrD_r   <= instrDNext_s;
            pcD_r      <= pcDNext_s;
            pcPlus4D_r <= pcPlus4DNext_s;
            validD_r   <= validDNext_s;
        end
    end

    assign fetchBus.PCF           = pcF_r;
    assign fetchBus.PCPlus4F      = pcPlus4F_s;
    assign fetchBus.InstrD        = instrD_r;
    assign fetchBus.PCD           = pcD_r;
    assign fetchBus.PCPlus4D      = pcPlus4D_r;
    assign fetchBus.ValidD        = validD_r;
    assign fetchBus.FlushE        = fetchBus.NeedBranchE;
    assign fetchBus.MisalignFault = fault_r;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, a sticky-fault sequence and
// randomized traffic against a spec-level reference model.
module tb_pc_fetch_stage;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    typedef struct packed {
        logic        rst;
        logic        stallF;
        logic        stallD;
        logic        flushD;
        logic        nb;
        logic [31:0] target;
        logic [31:0] pcF;
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic [31:0] p4D;
        logic        validD;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[18];

    pc_fetch_stage_if #(.XLEN(32)) bus ();

    pc_fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .fetchBus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return pc ^ 32'h5500_0000;
    endfunction

    assign bus.InstrF = imem(bus.PCF);

    function automatic vec_t mk(input logic r, input logic sf, input logic sd, input logic fd,
                                input logic nb, input logic [31:0] t, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] pd, input logic [31:0] p4,
                                input logic v, input logic f);
        vec_t x;
        x.rst = r; x.stallF = sf; x.stallD = sd; x.flushD = fd; x.nb = nb; x.target = t;
        x.pcF = pc; x.instrD = ins; x.pcD = pd; x.p4D = p4; x.validD = v; x.fault = f;
        return x;
    endfunction

    function automatic logic [31:0] effTarget(input logic [31:0] t);
        if (TRAP_ON && (t[1:0] != 2'b00)) return TRAP;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                         input logic nb, input logic [31:0] t);
        reset           = r;
        bus.StallF      = sf;
        bus.StallD      = sd;
        bus.FlushD      = fd;
        bus.NeedBranchE = nb;
        bus.PCTargetE   = t;
    endtask

    task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pd, input logic [31:0] p4, input logic v,
                              input logic f);
        chk({tag, ".PCF"}, bus.PCF, pc);
        chk({tag, ".PCPlus4F"}, bus.PCPlus4F, pc + 32'd4);
        chk({tag, ".InstrD"}, bus.InstrD, ins);
        chk({tag, ".PCD"}, bus.PCD, pd);
        chk({tag, ".PCPlus4D"}, bus.PCPlus4D, p4);
        chk({tag, ".ValidD"}, {31'd0, bus.ValidD}, {31'd0, v});
        chk({tag, ".MisalignFault"}, {31'd0, bus.MisalignFault}, {31'd0, f});
    endtask

    logic [31:0] mPc, mInstrD, mPcD, mP4D;
    logic        mValid, mFault;

    initial begin
        logic [31:0] t12;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        t12 = TRAP_ON ? TRAP : 32'h0000_0040;
        vecs[0]  = mk(1,0,0,0,0, 32'h0,        32'h0,        NOP,              32'h0,        32'h0,  0, 0);
        vecs[1]  = mk(0,0,0,0,0, 32'h0,        32'h4,        imem(32'h0),      32'h0,        32'h4,  1, 0);
        vecs[2]  = mk(0,0,0,0,0, 32'h0,        32'h8,        imem(32'h4),      32'h4,        32'h8,  1, 0);
        vecs[3]  = mk(0,0,0,0,0, 32'h0,        32'hC,        imem(32'h8),      32'h8,        32'hC,  1, 0);
        vecs[4]  = mk(0,0,0,0,0, 32'h0,        32'h10,       imem(32'hC),      32'hC,        32'h10, 1, 0);
        vecs[5]  = mk(0,0,0,0,1, 32'h40,       32'h40,       NOP,              32'hC,        32'h10, 0, 0);
        vecs[6]  = mk(0,0,0,0,0, 32'h0,        32'h44,       imem(32'h40),     32'h40,       32'h44, 1, 0);
        vecs[7]  = mk(0,1,1,0,1, 32'h80,       32'h80,       NOP,              32'h40,       32'h44, 0, 0);
        vecs[8]  = mk(0,1,0,0,0, 32'h0,        32'h80,       imem(32'h80),     32'h80,       32'h84, 1, 0);
        vecs[9]  = mk(0,1,0,0,0, 32'h0,        32'h80,       imem(32'h80),     32'h80,       32'h84, 1, 0);
        vecs[10] = mk(0,0,1,0,0, 32'h0,        32'h84,       imem(32'h80),     32'h80,       32'h84, 1, 0);
        vecs[11] = mk(0,0,0,1,0, 32'h0,        32'h88,       NOP,              32'h80,       32'h84, 0, 0);
        vecs[12] = mk(0,0,0,0,1, 32'h42,       t12,          NOP,              32'h80,       32'h84, 0, TRAP_ON);
        vecs[13] = mk(0,0,0,0,1, 32'h200,      32'h200,      NOP,              32'h80,       32'h84, 0, TRAP_ON);
        vecs[14] = mk(1,0,0,0,1, 32'h80,       32'h0,        NOP,              32'h0,        32'h0,  0, 0);
        vecs[15] = mk(0,0,0,0,1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,              32'h0,        32'h0,  0, 0);
        vecs[16] = mk(0,0,0,0,0, 32'h0,        32'h0,        imem(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0, 1, 0);
        vecs[17] = mk(0,0,1,1,0, 32'h0,        32'h4,        NOP,              32'hFFFFFFFC, 32'h0,  0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].stallF, vecs[i].stallD, vecs[i].flushD,
                  vecs[i].nb, vecs[i].target);
            #1;
            chk($sformatf("vec%0d.FlushE", i), {31'd0, bus.FlushE}, {31'd0, vecs[i].nb});
            @(posedge clk);
            #1;
            checkState($sformatf("vec%0d", i), vecs[i].pcF, vecs[i].instrD, vecs[i].pcD,
                       vecs[i].p4D, vecs[i].validD, vecs[i].fault);
        end

        // Misaligned redirect followed by free-running cycles: fault must persist.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0303);
        @(posedge clk); #1;
        chk("seq.redirPC", bus.PCF, TRAP_ON ? TRAP : 32'h0000_0300);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("seq.pc%0d", k), bus.PCF,
                (TRAP_ON ? TRAP : 32'h0000_0300) + 32'(4 * k));
            chk($sformatf("seq.fault%0d", k), {31'd0, bus.MisalignFault}, {31'd0, TRAP_ON});
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("seq.faultClr", {31'd0, bus.MisalignFault}, 32'd0);

        // Randomized traffic against the reference model.
        mPc = 32'h0; mInstrD = NOP; mPcD = 32'h0; mP4D = 32'h0; mValid = 1'b0; mFault = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        r, sf, sd, fd, nb;
            logic [31:0] t, fetched, pcOld;
            r  = ($urandom_range(0, 39) == 0);
            sf = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 3) == 0);
            fd = ($urandom_range(0, 7) == 0);
            nb = ($urandom_range(0, 5) == 0);
            t  = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            drive(r, sf, sd, fd, nb, t);
            #1;
            chk("rnd.FlushE", {31'd0, bus.FlushE}, {31'd0, nb});

            pcOld   = mPc;
            fetched = imem(pcOld);
            if (r) begin
                mPc = 32'h0; mInstrD = NOP; mPcD = 32'h0; mP4D = 32'h0;
                mValid = 1'b0; mFault = 1'b0;
            end else begin
                if (nb) mPc = effTarget(t);
                else if (!sf) mPc = pcOld + 32'd4;
                if (nb && TRAP_ON && (t[1:0] != 2'b00)) mFault = 1'b1;
                if (fd || nb) begin
                    mInstrD = NOP; mValid = 1'b0;
                end else if (!sd) begin
                    mInstrD = fetched; mPcD = pcOld; mP4D = pcOld + 32'd4; mValid = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            checkState($sformatf("rnd%0d", c), mPc, mInstrD, mPcD, mP4D, mValid, mFault);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
